// File: rtl/axi_default_slave_mo_pkg.sv
// Shared AXI constants and ID-width helper for the default-slave slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_default_slave_mo_pkg;

  // AXI response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXLEN is always 8 bits in AXI4
  localparam int W_LEN = 8;

  // Full interconnect ID = channel ID concatenated with transaction ID
  function automatic int sid_width(input int w_cid, input int w_id);
    return w_cid + w_id;
  endfunction

endpackage

// File: rtl/axi_default_slave_mo_if.sv
// AXI4 AW/W/B/AR/R bundle as seen on the unmapped-address port.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on every channel.
interface axi_default_slave_mo_if #(
  parameter int W_SID  = 8,
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int W_STRB = W_DATA / 8
);

  logic [W_SID-1:0]  AWID;
  logic [W_ADDR-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;

  logic [W_SID-1:0]  WID;
  logic [W_DATA-1:0] WDATA;
  logic [W_STRB-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [W_SID-1:0]  BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  logic [W_SID-1:0]  ARID;
  logic [W_ADDR-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;

  logic [W_SID-1:0]  RID;
  logic [W_DATA-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi_ds_fifo.sv
// Generic synchronous FIFO with registered full/empty derived from wrap-bit pointers.
// Latency: a pushed entry is visible at dout the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are state-only.
module axi_ds_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         AXI_CLK,
  input  logic         AXI_RSTn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  // DEPTH is a power of two, so the extra MSB distinguishes full from empty
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the queue immediately
  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop
  always_ff @(posedge AXI_CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_default_slave_mo.sv
// Multi-outstanding AXI default slave: error-terminates every write and read burst.
// Latency: B valid the cycle after the closing W beat; first R beat the cycle after AR.
// Backpressure: AW/AR ready = queue not full; W waits for an AW and B space; B/R hold until taken.
module axi_default_slave_mo
  import axi_default_slave_mo_pkg::*;
#(
  parameter int               W_CID  = 4,
  parameter int               W_ID   = 4,
  parameter int               W_ADDR = 32,
  parameter int               W_DATA = 32,
  parameter int               W_STRB = W_DATA / 8,
  parameter int               W_SID  = sid_width(W_CID, W_ID),
  parameter int               DEPTH  = 4,
  parameter logic [1:0]       RESP   = RESP_DECERR,
  parameter logic [W_DATA-1:0] RFILL = '1
) (
  input  logic                  AXI_CLK,
  input  logic                  AXI_RSTn,
  axi_default_slave_mo_if.slave bus,
  output logic                  ERR_WLAST
);

  localparam int W_CMD = W_SID + W_LEN;

  logic             awq_push, awq_pop, awq_full, awq_empty;
  logic [W_CMD-1:0] awq_dout;
  logic [W_SID-1:0] aw_head_id;
  logic [W_LEN-1:0] aw_head_len;

  logic             bq_push, bq_pop, bq_full, bq_empty;
  logic [W_SID-1:0] bq_dout;

  logic             arq_push, arq_pop, arq_full, arq_empty;
  logic [W_CMD-1:0] arq_dout;
  logic [W_SID-1:0] ar_head_id;
  logic [W_LEN-1:0] ar_head_len;

  logic [W_LEN-1:0] wcnt;
  logic [W_LEN-1:0] rcnt;
  logic             w_fire, w_at_len, w_close;
  logic             r_fire, r_last;

  // Address, size, burst, data, strobe and WID carry no meaning for an error slave
  logic [W_ADDR-1:0] unused_awaddr;
  logic [W_ADDR-1:0] unused_araddr;
  logic [W_DATA-1:0] unused_wdata;
  logic [W_STRB-1:0] unused_wstrb;
  logic [W_SID-1:0]  unused_wid;
  logic [9:0]        unused_size_burst;

  assign unused_awaddr     = bus.AWADDR;
  assign unused_araddr     = bus.ARADDR;
  assign unused_wdata      = bus.WDATA;
  assign unused_wstrb      = bus.WSTRB;
  assign unused_wid        = bus.WID;
  assign unused_size_burst = {bus.AWSIZE, bus.AWBURST, bus.ARSIZE, bus.ARBURST};

  // ---------------- write path ----------------
  assign bus.AWREADY = ~awq_full;
  assign awq_push    = bus.AWVALID & ~awq_full;
  assign {aw_head_id, aw_head_len} = awq_dout;

  // A beat is only taken when its AW is known and its B has somewhere to go
  assign bus.WREADY = ~awq_empty & ~bq_full;
  assign w_fire     = bus.WVALID & ~awq_empty & ~bq_full;
  assign w_at_len   = (wcnt == aw_head_len);
  // Either the count or an early WLAST ends the burst, so a bad master cannot wedge the queue
  assign w_close    = w_fire & (w_at_len | bus.WLAST);
  assign awq_pop    = w_close;
  assign bq_push    = w_close;

  assign bus.BVALID = ~bq_empty;
  assign bus.BID    = bq_dout;
  assign bus.BRESP  = RESP;
  assign bq_pop     = ~bq_empty & bus.BREADY;

  // ---------------- read path ----------------
  assign bus.ARREADY = ~arq_full;
  assign arq_push    = bus.ARVALID & ~arq_full;
  assign {ar_head_id, ar_head_len} = arq_dout;

  assign r_last     = ~arq_empty & (rcnt == ar_head_len);
  assign r_fire     = ~arq_empty & bus.RREADY;
  assign arq_pop    = r_fire & r_last;

  assign bus.RVALID = ~arq_empty;
  assign bus.RID    = ar_head_id;
  assign bus.RDATA  = RFILL;
  assign bus.RRESP  = RESP;
  assign bus.RLAST  = r_last;

  // Count W beats against the head AW and latch any WLAST/length disagreement
  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      wcnt      <= '0;
      ERR_WLAST <= 1'b0;
    end else if (w_fire) begin
      wcnt <= w_close ? '0 : wcnt + W_LEN'(1);
      if (bus.WLAST != w_at_len) ERR_WLAST <= 1'b1;
    end
  end

  // Count R beats of the head AR; the next burst starts at beat 0 right after RLAST
  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      rcnt <= '0;
    end else if (r_fire) begin
      rcnt <= r_last ? '0 : rcnt + W_LEN'(1);
    end
  end

  axi_ds_fifo #(.W(W_CMD), .DEPTH(DEPTH)) u_awq (
    .AXI_CLK (AXI_CLK),
    .AXI_RSTn(AXI_RSTn),
    .push    (awq_push),
    .din     ({bus.AWID, bus.AWLEN}),
    .pop     (awq_pop),
    .dout    (awq_dout),
    .full    (awq_full),
    .empty   (awq_empty)
  );

  axi_ds_fifo #(.W(W_SID), .DEPTH(DEPTH)) u_bq (
    .AXI_CLK (AXI_CLK),
    .AXI_RSTn(AXI_RSTn),
    .push    (bq_push),
    .din     (aw_head_id),
    .pop     (bq_pop),
    .dout    (bq_dout),
    .full    (bq_full),
    .empty   (bq_empty)
  );

  axi_ds_fifo #(.W(W_CMD), .DEPTH(DEPTH)) u_arq (
    .AXI_CLK (AXI_CLK),
    .AXI_RSTn(AXI_RSTn),
    .push    (arq_push),
    .din     ({bus.ARID, bus.ARLEN}),
    .pop     (arq_pop),
    .dout    (arq_dout),
    .full    (arq_full),
    .empty   (arq_empty)
  );

endmodule

// File: tb/tb_axi_default_slave_mo.sv
// Bench for the AXI default slave: directed tables, multi-cycle corner sequences, random traffic.
// Latency: n/a.
// Backpressure: exercised through random BREADY/RREADY and queue-full phases.
module tb_axi_default_slave_mo;

  localparam int DEPTH = 4;

  logic AXI_CLK  = 1'b0;
  logic AXI_RSTn = 1'b0;
  logic ERR_WLAST;

  always #5 AXI_CLK = ~AXI_CLK;

  axi_default_slave_mo_if #(.W_SID(8), .W_ADDR(32), .W_DATA(32)) bus ();

  axi_default_slave_mo dut (
    .AXI_CLK  (AXI_CLK),
    .AXI_RSTn (AXI_RSTn),
    .bus      (bus),
    .ERR_WLAST(ERR_WLAST)
  );

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] len;
  } cmd_t;

  typedef struct {
    logic [7:0] id;
    logic [7:0] len;
    int         last_beat;   // beat index carrying WLAST
    int         exp_beats;   // beats the slave should accept
    logic       exp_err;     // ERR_WLAST after the burst
  } wvec_t;

  typedef struct {
    logic [7:0] id;
    logic [7:0] len;
    bit         toggle;      // RREADY alternates 1/0
  } rvec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive slot is 1 time unit after the rising edge; samples are on the falling edge
  task automatic tick();
    @(posedge AXI_CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge AXI_CLK);
  endtask

  task automatic idle_inputs();
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [7:0] len);
    bit done = 0;
    bus.AWVALID = 1'b1; bus.AWID = id; bus.AWLEN = len;
    bus.AWADDR = $urandom; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01;
    for (int i = 0; i < 50 && !done; i++) begin
      sample();
      done = bus.AWREADY;
      tick();
    end
    bus.AWVALID = 1'b0;
    chk("aw_accept", done, 1);
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [7:0] len);
    bit done = 0;
    bus.ARVALID = 1'b1; bus.ARID = id; bus.ARLEN = len;
    bus.ARADDR = $urandom; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01;
    for (int i = 0; i < 50 && !done; i++) begin
      sample();
      done = bus.ARREADY;
      tick();
    end
    bus.ARVALID = 1'b0;
    chk("ar_accept", done, 1);
  endtask

  task automatic run_write(input wvec_t v);
    int acc = 0;
    int cyc = 0;
    bus.BREADY = 1'b1;
    aw_send(v.id, v.len);
    bus.WVALID = 1'b1;
    bus.WLAST  = (v.last_beat == 0);
    while (acc < v.exp_beats && cyc < 40) begin
      sample();
      if (bus.WREADY) acc++;
      cyc++;
      tick();
      bus.WLAST = (acc == v.last_beat);
      bus.WDATA = $urandom;
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    chk("w_beats", acc, v.exp_beats);
    chk("w_cycles", cyc, v.exp_beats);
    sample();
    chk("w_ready_after_close", bus.WREADY, 0);
    chk("b_valid", bus.BVALID, 1);
    chk("b_id", bus.BID, v.id);
    chk("b_resp", bus.BRESP, 2'b11);
    chk("err_wlast", ERR_WLAST, v.exp_err);
    tick();
    sample();
    chk("b_popped", bus.BVALID, 0);
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic run_read(input rvec_t v);
    int beat = 0;
    int cyc = 0;
    bus.RREADY = 1'b0;
    ar_send(v.id, v.len);
    bus.RREADY = 1'b1;
    while (beat <= int'(v.len) && cyc < 600) begin
      sample();
      chk("r_valid", bus.RVALID, 1);
      chk("r_id", bus.RID, v.id);
      chk("r_data", bus.RDATA, 32'hFFFF_FFFF);
      chk("r_resp", bus.RRESP, 2'b11);
      chk("r_last", bus.RLAST, beat == int'(v.len));
      if (bus.RVALID && bus.RREADY) beat++;
      cyc++;
      tick();
      bus.RREADY = v.toggle ? ~bus.RREADY : 1'b1;
    end
    chk("r_beats", beat, int'(v.len) + 1);
    bus.RREADY = 1'b0;
    sample();
    chk("r_done", bus.RVALID, 0);
    tick();
  endtask

  // Five AWs with W held off: the fifth stalls until a burst completes
  task automatic aw_fill_test();
    int  w_acc = 0;
    int  b_cnt = 0;
    bit  aw5 = 0;
    bus.BREADY = 1'b0;
    bus.AWVALID = 1'b1;
    bus.AWLEN = 8'd0;
    for (int i = 0; i < 5; i++) begin
      bus.AWID = 8'(8'h40 + i);
      sample();
      chk("aw_fill_ready", bus.AWREADY, i < DEPTH);
      tick();
    end
    sample();
    chk("aw_full_hold", bus.AWREADY, 0);
    tick();
    bus.WVALID = 1'b1; bus.WLAST = 1'b1; bus.BREADY = 1'b1;
    for (int c = 0; c < 60 && (b_cnt < 5 || !aw5); c++) begin
      sample();
      if (bus.AWVALID && bus.AWREADY) aw5 = 1;
      if (bus.WVALID && bus.WREADY) w_acc++;
      if (bus.BVALID) begin
        chk("b_order", bus.BID, 8'(8'h40 + b_cnt));
        b_cnt++;
      end
      tick();
      if (aw5) bus.AWVALID = 1'b0;
      if (w_acc == 5) bus.WVALID = 1'b0;
    end
    chk("aw5_accepted", aw5, 1);
    chk("b_count", b_cnt, 5);
    idle_inputs();
  endtask

  // Two ARs back to back: three R beats with no bubble
  task automatic ar_b2b_test();
    logic [7:0] exp_id   [3] = '{8'h01, 8'h01, 8'h02};
    logic       exp_last [3] = '{1'b0, 1'b1, 1'b1};
    bus.RREADY = 1'b1;
    bus.ARVALID = 1'b1; bus.ARID = 8'h01; bus.ARLEN = 8'd1;
    sample();
    chk("ar_b2b_0", bus.ARREADY, 1);
    tick();
    bus.ARID = 8'h02; bus.ARLEN = 8'd0;
    for (int k = 0; k < 3; k++) begin
      sample();
      if (k == 0) chk("ar_b2b_1", bus.ARREADY, 1);
      chk("r_b2b_valid", bus.RVALID, 1);
      chk("r_b2b_id", bus.RID, exp_id[k]);
      chk("r_b2b_last", bus.RLAST, exp_last[k]);
      tick();
      bus.ARVALID = 1'b0;
    end
    sample();
    chk("r_b2b_end", bus.RVALID, 0);
    tick();
    idle_inputs();
  endtask

  // Reset mid-burst with a pending B, an active R burst and an open W burst
  task automatic reset_mid_test();
    bus.BREADY = 1'b0;
    aw_send(8'h66, 8'd0);
    bus.WVALID = 1'b1; bus.WLAST = 1'b1;
    sample();
    tick();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    ar_send(8'h77, 8'd7);
    bus.RREADY = 1'b1;
    tick();
    aw_send(8'h88, 8'd3);
    bus.WVALID = 1'b1;
    sample();
    chk("pre_rst_rvalid", bus.RVALID, 1);
    chk("pre_rst_bvalid", bus.BVALID, 1);
    chk("pre_rst_wready", bus.WREADY, 1);
    #2 AXI_RSTn = 1'b0;
    #1;
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_bvalid", bus.BVALID, 0);
    chk("rst_wready", bus.WREADY, 0);
    chk("rst_err", ERR_WLAST, 0);
    idle_inputs();
    tick();
    tick();
    AXI_RSTn = 1'b1;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    sample();
    chk("post_rst_awready", bus.AWREADY, 1);
    chk("post_rst_arready", bus.ARREADY, 1);
    for (int c = 0; c < 6; c++) begin
      sample();
      chk("post_rst_no_b", bus.BVALID, 0);
      chk("post_rst_no_r", bus.RVALID, 0);
    end
    tick();
    idle_inputs();
  endtask

  // Random concurrent traffic against a queue-level model of the slave
  task automatic random_phase(input int ncyc);
    cmd_t       awq_m[$];
    logic [7:0] bq_m[$];
    logic [7:0] rid_m[$];
    logic       rlast_m[$];
    cmd_t       tmp;
    int         w_beat = 0;
    int         ar_out = 0;
    bit         aw_hs, w_hs, b_hs, ar_hs, r_hs;
    for (int c = 0; c < ncyc; c++) begin
      if (!bus.AWVALID && $urandom_range(2) == 0) begin
        bus.AWVALID = 1'b1;
        bus.AWID    = 8'($urandom);
        bus.AWLEN   = 8'($urandom_range(3));
        bus.AWADDR  = $urandom;
      end
      if (!bus.ARVALID && $urandom_range(2) == 0) begin
        bus.ARVALID = 1'b1;
        bus.ARID    = 8'($urandom);
        bus.ARLEN   = ($urandom_range(31) == 0) ? 8'd255 : 8'($urandom_range(7));
        bus.ARADDR  = $urandom;
      end
      bus.WVALID = 1'($urandom_range(1));
      bus.WLAST  = (awq_m.size() > 0) && (w_beat == int'(awq_m[0].len));
      bus.WDATA  = $urandom;
      bus.WSTRB  = 4'($urandom);
      bus.BREADY = ((c % 200) < 60) ? 1'b0 : ($urandom_range(3) != 0);
      bus.RREADY = ((c % 170) < 40) ? 1'b0 : ($urandom_range(3) != 0);
      sample();
      chk("rnd_awready", bus.AWREADY, awq_m.size() < DEPTH);
      chk("rnd_arready", bus.ARREADY, ar_out < DEPTH);
      chk("rnd_wready", bus.WREADY, (awq_m.size() > 0) && (bq_m.size() < DEPTH));
      chk("rnd_bvalid", bus.BVALID, bq_m.size() > 0);
      chk("rnd_rvalid", bus.RVALID, rid_m.size() > 0);
      if (bus.BVALID && bq_m.size() > 0) begin
        chk("rnd_bid", bus.BID, bq_m[0]);
        chk("rnd_bresp", bus.BRESP, 2'b11);
      end
      if (bus.RVALID && rid_m.size() > 0) begin
        chk("rnd_rid", bus.RID, rid_m[0]);
        chk("rnd_rlast", bus.RLAST, rlast_m[0]);
        chk("rnd_rdata", bus.RDATA, 32'hFFFF_FFFF);
      end
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      b_hs  = bus.BVALID && bus.BREADY;
      ar_hs = bus.ARVALID && bus.ARREADY;
      r_hs  = bus.RVALID && bus.RREADY;
      if (b_hs && bq_m.size() > 0) void'(bq_m.pop_front());
      if (w_hs && awq_m.size() > 0) begin
        if (w_beat == int'(awq_m[0].len)) begin
          bq_m.push_back(awq_m[0].id);
          void'(awq_m.pop_front());
          w_beat = 0;
        end else begin
          w_beat++;
        end
      end
      if (aw_hs) begin
        tmp.id  = bus.AWID;
        tmp.len = bus.AWLEN;
        awq_m.push_back(tmp);
      end
      if (r_hs && rid_m.size() > 0) begin
        if (rlast_m[0]) ar_out--;
        void'(rid_m.pop_front());
        void'(rlast_m.pop_front());
      end
      if (ar_hs) begin
        for (int b = 0; b <= int'(bus.ARLEN); b++) begin
          rid_m.push_back(bus.ARID);
          rlast_m.push_back(b == int'(bus.ARLEN));
        end
        ar_out++;
      end
      tick();
      if (aw_hs) bus.AWVALID = 1'b0;
      if (ar_hs) bus.ARVALID = 1'b0;
    end
    idle_inputs();
    sample();
    chk("rnd_err_wlast", ERR_WLAST, 0);
    tick();
  endtask

  // Hard stop if anything wedges the run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t wv [3];
    rvec_t rv [3];

    wv[0] = '{8'h11, 8'd3, 3, 4, 1'b0};   // normal 4-beat burst
    wv[1] = '{8'h22, 8'd0, 0, 1, 1'b0};   // single beat
    wv[2] = '{8'h33, 8'd3, 1, 2, 1'b1};   // early WLAST closes after 2 beats
    rv[0] = '{8'h5A, 8'd7,   1'b1};       // stalled every other cycle
    rv[1] = '{8'hC3, 8'd0,   1'b0};       // single beat
    rv[2] = '{8'h0F, 8'd255, 1'b0};       // longest burst

    idle_inputs();
    AXI_RSTn = 1'b0;
    tick();
    tick();
    AXI_RSTn = 1'b1;
    sample();
    chk("rst_awready", bus.AWREADY, 1);
    chk("rst_arready", bus.ARREADY, 1);
    chk("rst_wready", bus.WREADY, 0);
    chk("rst_bvalid", bus.BVALID, 0);
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_rlast", bus.RLAST, 0);
    chk("rst_err_wlast", ERR_WLAST, 0);
    chk("const_bresp", bus.BRESP, 2'b11);
    chk("const_rresp", bus.RRESP, 2'b11);
    chk("const_rdata", bus.RDATA, 32'hFFFF_FFFF);
    tick();

    // W before any AW must be held off
    bus.WVALID = 1'b1; bus.WLAST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("w_without_aw", bus.WREADY, 0);
      tick();
    end
    idle_inputs();

    for (int i = 0; i < 3; i++) run_write(wv[i]);
    for (int i = 0; i < 3; i++) run_read(rv[i]);

    aw_fill_test();
    ar_b2b_test();
    reset_mid_test();
    random_phase(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
